switch_conditioner: RTL



---
 rtl/switch_conditioner.sv | 96 +++++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// Purpose : synchronise + debounce two board switches; switch 1 -> press-to-toggle
//           run/pause level, switch 2 -> clean clear level.
// Latency : a clean input step reaches the stable level (and o_Run/o_Press_1/o_Clear)
//           on the (DEBOUNCE_LIMIT+2)-th rising edge after the step.
// Backpressure: none; outputs are levels/pulses, always valid.
// Ports   : i_Clk, i_Rst_L (async active-low), i_Switch_1/2 raw switches (1 = pressed),
//           o_Run run/pause level, o_Clear debounced clear level,
//           o_Press_1 one-cycle pulse per accepted switch-1 press.
// Option  : define CLEAR_PAUSES_EN to force o_Run low (and suppress presses) while
//           the debounced clear level is high.
module switch_conditioner #(
    parameter  int DEBOUNCE_LIMIT = 250000,
    localparam int CNT_WIDTH      = $clog2(DEBOUNCE_LIMIT)
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Run,
    output logic o_Clear,
    output logic o_Press_1
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Index 0 = switch 1 (run/pause), index 1 = switch 2 (clear).
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           stable_q;
    logic [1:0]           stable_d;
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];
    logic                 run_q;
    logic                 run_d;
    logic                 press_q;
    logic                 press_d;
    logic                 press_acc;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                // Any return to the accepted level wipes partial progress.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end

        // A press is the accepted 0->1 transition of switch 1; it is applied on the
        // same edge the stable level updates so the counter sees both together.
        press_acc = stable_d[0] & ~stable_q[0];

`ifdef CLEAR_PAUSES_EN
        if (stable_q[1]) begin
            run_d   = 1'b0;
            press_d = 1'b0;
        end else begin
            run_d   = run_q ^ press_acc;
            press_d = press_acc;
        end
`else
        run_d   = run_q ^ press_acc;
        press_d = press_acc;
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            run_q    <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= {i_Switch_2, i_Switch_1};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            run_q    <= run_d;
            press_q  <= press_d;
        end
    end

    assign o_Run     = run_q;
    assign o_Clear   = stable_q[1];
    assign o_Press_1 = press_q;

endmodule
